sipo_deserializer: RTL and testbench

- Serial-in/parallel-out stage that consumes the 1-bit registered output of the D-flop stage and assembles WIDTH-bit words.
- Each completed word is presented on a valid/ready output holding register.
- A word that completes while the holding register is occupied and not being drained is dropped and flagged.
- A frame-sync input realigns word boundaries.

---
 rtl/sipo_deserializer.sv | 103 ++++++++++
 tb/tb_sipo_deserializer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. Assembles WIDTH-bit words from a qualified bit
// stream and presents each word in a valid/ready holding register with a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CW-1:0]    bit_cnt
);

  // Only WIDTH-1 bits are ever stored; the last bit goes straight from din into the word.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] sync_word;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;
  logic             complete;
  logic             transfer;

  function automatic logic [WIDTH-1:0] join_bit(input logic [WIDTH-2:0] s, input logic b);
    if (MSB_FIRST) return {s, b};
    else           return {b, s};
  endfunction

  function automatic logic [WIDTH-2:0] keep_partial(input logic [WIDTH-1:0] w);
    if (MSB_FIRST) return w[WIDTH-2:0];
    else           return w[WIDTH-1:1];
  endfunction

  always_comb begin
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ovr_d     = ovr_q;
    complete  = 1'b0;
    transfer  = valid_q && dout_ready;
    word      = join_bit(shift_q, din);
    sync_word = join_bit('0, din);

    // frame_sync takes priority over completion and restarts the word
    if (frame_sync) begin
      shift_d = din_en ? keep_partial(sync_word) : '0;
      cnt_d   = din_en ? CW'(1) : '0;
    end else if (din_en) begin
      if (cnt_q == CW'(WIDTH-1)) begin
        complete = 1'b1;
        shift_d  = '0;
        cnt_d    = '0;
      end else begin
        shift_d = keep_partial(word);
        cnt_d   = cnt_q + CW'(1);
      end
    end

    if (transfer)    valid_d = 1'b0;
    if (clr_overrun) ovr_d   = 1'b0;

    // A drop sets overrun after the clear so a coincident drop wins
    if (complete) begin
      if (!valid_q || dout_ready) begin
        dout_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances share one stimulus stream
// and are compared every cycle against a bit-queue reference model.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din = 1'b0;
  logic       din_en = 1'b0;
  logic       frame_sync = 1'b0;
  logic       dout_ready = 1'b0;
  logic       clr_overrun = 1'b0;

  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the partial word as a list of received bits, plus the holding register
  bit         bits_q[$];
  logic [7:0] exp_dout_m = '0;
  logic [7:0] exp_dout_l = '0;
  logic       exp_valid = 1'b0;
  logic       exp_ovr = 1'b0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .frame_sync(frame_sync),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .clr_overrun(clr_overrun), .bit_cnt(cnt_m)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en), .frame_sync(frame_sync),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .clr_overrun(clr_overrun), .bit_cnt(cnt_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout_m"},  32'(dout_m),  32'(exp_dout_m));
    check({tag, ".dout_l"},  32'(dout_l),  32'(exp_dout_l));
    check({tag, ".valid_m"}, 32'(valid_m), 32'(exp_valid));
    check({tag, ".valid_l"}, 32'(valid_l), 32'(exp_valid));
    check({tag, ".ovr_m"},   32'(ovr_m),   32'(exp_ovr));
    check({tag, ".ovr_l"},   32'(ovr_l),   32'(exp_ovr));
    check({tag, ".cnt_m"},   32'(cnt_m),   32'(bits_q.size()));
    check({tag, ".cnt_l"},   32'(cnt_l),   32'(bits_q.size()));
  endtask

  task automatic model_reset();
    bits_q.delete();
    exp_dout_m = '0;
    exp_dout_l = '0;
    exp_valid  = 1'b0;
    exp_ovr    = 1'b0;
  endtask

  // One clock: apply inputs, advance the model by the rules, compare after the edge
  task automatic step(input logic en, input logic d, input logic fs, input logic rdy, input logic clr);
    logic       done;
    logic [7:0] wm, wl;
    din_en = en; din = d; frame_sync = fs; dout_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    done = 1'b0; wm = '0; wl = '0;
    if (fs) begin
      bits_q.delete();
      if (en) bits_q.push_back(d);
    end else if (en) begin
      bits_q.push_back(d);
      if (bits_q.size() == 8) begin
        done = 1'b1;
        for (int i = 0; i < 8; i++) begin
          wm = wm | (8'(bits_q[i]) << (7 - i));
          wl = wl | (8'(bits_q[i]) << i);
        end
        bits_q.delete();
      end
    end
    if (done && exp_valid && !rdy) begin
      exp_ovr = 1'b1;
    end else begin
      if (clr) exp_ovr = 1'b0;
      if (done) begin
        exp_dout_m = wm;
        exp_dout_l = wl;
        exp_valid  = 1'b1;
      end else if (rdy) begin
        exp_valid = 1'b0;
      end
    end
    #1;
    check_all("step");
    $display("step en=%0b din=%0b fs=%0b rdy=%0b clr=%0b -> dout_m=%02h dout_l=%02h v=%0b ovr=%0b cnt=%0d",
             en, d, fs, rdy, clr, dout_m, dout_l, valid_m, ovr_m, cnt_m);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, rdy, 1'b0);
  endtask

  task automatic hold_reset();
    din_en = 0; din = 0; frame_sync = 0; dout_ready = 0; clr_overrun = 0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check_all("in_reset");
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // B2 stream: MSB-first yields B2, LSB-first yields 4D
    send_byte(8'hB2, 1'b1);
    check("b2_msb", 32'(dout_m), 32'h0000_00B2);
    check("b2_lsb", 32'(dout_l), 32'h0000_004D);
    check("b2_valid", 32'(valid_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("b2_one_cycle", 32'(valid_m), 32'd0);
    check("b2_cnt", 32'(cnt_m), 32'd0);

    // Back-to-back words with a draining consumer
    send_byte(8'hA5, 1'b1);
    check("a5", 32'(dout_m), 32'h0000_00A5);
    send_byte(8'h3C, 1'b1);
    check("3c", 32'(dout_m), 32'h0000_003C);
    check("3c_valid", 32'(valid_m), 32'd1);
    check("no_ovr", 32'(ovr_m), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Stalled consumer: second word is dropped
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    check("stall_dout", 32'(dout_m), 32'h0000_00A5);
    check("stall_valid", 32'(valid_m), 32'd1);
    check("stall_ovr", 32'(ovr_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_valid", 32'(valid_m), 32'd0);
    check("ovr_sticky", 32'(ovr_m), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_clr", 32'(ovr_m), 32'd0);

    // Frame sync discards a 5-bit partial word
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("sync_cnt", 32'(cnt_m), 32'd1);
    check("sync_novalid", 32'(valid_m), 32'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("sync_word", 32'(dout_m), 32'h0000_0081);
    check("sync_valid", 32'(valid_m), 32'd1);

    // Async reset mid-cycle with a pending word and overrun
    send_byte(8'h5A, 1'b0);
    send_byte(8'h11, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    din_en = 0; dout_ready = 0;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 32'(valid_m), 32'd0);
    check("arst_dout", 32'(dout_m), 32'd0);
    check("arst_ovr", 32'(ovr_m), 32'd0);
    check("arst_cnt", 32'(cnt_m), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send_byte(8'hFF, 1'b1);
    check("ff", 32'(dout_m), 32'h0000_00FF);

    // Randomized traffic
    hold_reset();
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(99) < 70), 1'($urandom_range(1)), 1'($urandom_range(99) < 4),
           1'($urandom_range(99) < 55), 1'($urandom_range(99) < 6));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
